// File: rtl/icache_pkg.sv
// Shared constants, FSM state encoding and address helpers for the icache refill path.
package icache_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int INDEX_WIDTH  = 6;
    localparam int OFFSET_WIDTH = 4;
    localparam int BEAT_WIDTH   = 64;
    localparam int LINE_WIDTH   = 128;
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_BEAT0 = 3'd2,
        ST_BEAT1 = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_t;

    function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFSET_WIDTH +: INDEX_WIDTH];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_sram_port_mux.sv
// Selects between the fetch read path (idle) and the refill write path (busy)
// onto the single data SRAM port.
module icache_sram_port_mux
    import icache_pkg::*;
(
    input  logic                   busy,
    input  logic                   fetch_csb,
    input  logic [INDEX_WIDTH-1:0] fetch_addr,
    input  logic                   ref_csb,
    input  logic                   ref_web,
    input  logic [1:0]             ref_wmask,
    input  logic [INDEX_WIDTH-1:0] ref_addr,
    input  logic [LINE_WIDTH-1:0]  ref_din,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [1:0]             sram_wmask,
    output logic [INDEX_WIDTH-1:0] sram_addr,
    output logic [LINE_WIDTH-1:0]  sram_din
);

    // Refill owns the port while busy; otherwise fetch reads pass straight through.
    always_comb begin
        if (busy) begin
            sram_csb   = ref_csb;
            sram_web   = ref_web;
            sram_wmask = ref_wmask;
            sram_addr  = ref_addr;
            sram_din   = ref_din;
        end else begin
            sram_csb   = fetch_csb;
            sram_web   = 1'b1;
            sram_wmask = 2'b00;
            sram_addr  = fetch_addr;
            sram_din   = '0;
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Icache miss handler: requests a line, writes its two beats into the data SRAM
// half by half, then installs the tag.
//
// Handshakes: a channel transfers on a cycle where valid and ready are both high
// at the rising clock edge; valid, once raised, holds with stable payload until
// that transfer. The memory response channel has no ready: every beat offered
// while waiting for one is taken.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   miss_valid,
    input  logic [ADDR_WIDTH-1:0]  miss_addr,
    output logic                   miss_ready,
    input  logic                   flush,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [BEAT_WIDTH-1:0]  mem_resp_data,
    input  logic                   fetch_csb,
    input  logic [INDEX_WIDTH-1:0] fetch_addr,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [1:0]             sram_wmask,
    output logic [INDEX_WIDTH-1:0] sram_addr,
    output logic [LINE_WIDTH-1:0]  sram_din,
    output logic                   tag_we,
    output logic [INDEX_WIDTH-1:0] tag_idx,
    output logic [TAG_WIDTH-1:0]   tag_wdata,
    output logic                   busy,
    output logic                   fill_done,
    output logic [2:0]             state_dbg
);

    refill_state_t          state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [BEAT_WIDTH-1:0]  beat_q;
    logic [1:0]             wmask_q;
    logic                   wr_pend_q;
    logic                   drop_q;

    logic                   accept;
    logic                   beat_acc;
    logic                   ref_csb;
    logic                   ref_web;
    logic [1:0]             ref_wmask;
    logic [LINE_WIDTH-1:0]  ref_din;
    logic                   fetch_csb_gated;

    assign accept   = (state_q == ST_IDLE) && miss_valid && !flush;
    assign beat_acc = mem_resp_valid && ((state_q == ST_BEAT0) || (state_q == ST_BEAT1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_aL) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a flush in REQ wins over a simultaneous request handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept)              state_d = ST_REQ;
            ST_REQ: begin
                if (flush)                     state_d = ST_IDLE;
                else if (mem_req_ready)        state_d = ST_BEAT0;
            end
            ST_BEAT0: if (mem_resp_valid)      state_d = ST_BEAT1;
            ST_BEAT1: if (mem_resp_valid)      state_d = ST_DONE;
            ST_DONE:                           state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Miss capture, registered beat write and the drop flag for post-handshake flushes.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            tag_q     <= '0;
            idx_q     <= '0;
            beat_q    <= '0;
            wmask_q   <= 2'b00;
            wr_pend_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (accept) begin
                tag_q <= addr_tag(miss_addr);
                idx_q <= addr_index(miss_addr);
            end
            wr_pend_q <= beat_acc;
            if (beat_acc) begin
                beat_q  <= mem_resp_data;
                wmask_q <= (state_q == ST_BEAT0) ? 2'b01 : 2'b10;
            end
            if (state_q == ST_DONE)
                drop_q <= 1'b0;
            else if (flush && ((state_q == ST_BEAT0) || (state_q == ST_BEAT1)))
                drop_q <= 1'b1;
        end
    end

    // Output decode from state and the registered write slot.
    always_comb begin
        miss_ready    = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        mem_req_valid = (state_q == ST_REQ);
        mem_req_addr  = line_align({tag_q, idx_q, {OFFSET_WIDTH{1'b0}}});
        tag_we        = (state_q == ST_DONE);
        tag_idx       = idx_q;
        tag_wdata     = tag_q;
        fill_done     = (state_q == ST_DONE) && !drop_q;
        ref_csb       = !wr_pend_q;
        ref_web       = !wr_pend_q;
        ref_wmask     = wr_pend_q ? wmask_q : 2'b00;
        ref_din       = wr_pend_q ? {beat_q, beat_q} : '0;
        state_dbg     = state_q;
    end

    // Fetch cannot select the SRAM while reset is held.
    assign fetch_csb_gated = fetch_csb | ~rst_aL;

    icache_sram_port_mux u_port_mux (
        .busy       (busy),
        .fetch_csb  (fetch_csb_gated),
        .fetch_addr (fetch_addr),
        .ref_csb    (ref_csb),
        .ref_web    (ref_web),
        .ref_wmask  (ref_wmask),
        .ref_addr   (idx_q),
        .ref_din    (ref_din),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din)
    );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: scenario tasks drive misses/beats, a negedge
// monitor checks SRAM and tag writes against expected queues.
module tb_icache_refill_ctrl;
  import icache_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_aL;
  logic                   miss_valid;
  logic [ADDR_WIDTH-1:0]  miss_addr;
  logic                   miss_ready;
  logic                   flush;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [ADDR_WIDTH-1:0]  mem_req_addr;
  logic                   mem_resp_valid;
  logic [BEAT_WIDTH-1:0]  mem_resp_data;
  logic                   fetch_csb;
  logic [INDEX_WIDTH-1:0] fetch_addr;
  logic                   sram_csb;
  logic                   sram_web;
  logic [1:0]             sram_wmask;
  logic [INDEX_WIDTH-1:0] sram_addr;
  logic [LINE_WIDTH-1:0]  sram_din;
  logic                   tag_we;
  logic [INDEX_WIDTH-1:0] tag_idx;
  logic [TAG_WIDTH-1:0]   tag_wdata;
  logic                   busy;
  logic                   fill_done;
  logic [2:0]             state_dbg;

  localparam int WR_W  = 2 + INDEX_WIDTH + LINE_WIDTH;
  localparam int TAG_W = INDEX_WIDTH + TAG_WIDTH;

  logic [WR_W-1:0]       exp_wr_q[$];
  logic [TAG_W-1:0]      exp_tag_q[$];
  logic [LINE_WIDTH-1:0] sram_model [64];

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int tag_cnt = 0;
  int fill_cnt = 0;

  icache_refill_ctrl dut (
    .clk            (clk),
    .rst_aL         (rst_aL),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .miss_ready     (miss_ready),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .fetch_csb      (fetch_csb),
    .fetch_addr     (fetch_addr),
    .sram_csb       (sram_csb),
    .sram_web       (sram_web),
    .sram_wmask     (sram_wmask),
    .sram_addr      (sram_addr),
    .sram_din       (sram_din),
    .tag_we         (tag_we),
    .tag_idx        (tag_idx),
    .tag_wdata      (tag_wdata),
    .busy           (busy),
    .fill_done      (fill_done),
    .state_dbg      (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: SRAM writes, tag writes, fill_done pulses
  always @(negedge clk) begin
    logic [WR_W-1:0]  e_wr;
    logic [TAG_W-1:0] e_tag;
    if (rst_aL && !sram_csb && !sram_web) begin
      wr_cnt++;
      if (sram_wmask[0]) sram_model[sram_addr][63:0]   = sram_din[63:0];
      if (sram_wmask[1]) sram_model[sram_addr][127:64] = sram_din[127:64];
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL sram_write unexpected: got mask=%b addr=%h din=%h, required none", sram_wmask, sram_addr, sram_din);
      end else begin
        e_wr = exp_wr_q.pop_front();
        if ({sram_wmask, sram_addr, sram_din} !== e_wr) begin
          errors++;
          $display("FAIL sram_write: got %h required %h", {sram_wmask, sram_addr, sram_din}, e_wr);
        end
      end
    end
    if (rst_aL && tag_we) begin
      tag_cnt++;
      checks++;
      if (exp_tag_q.size() == 0) begin
        errors++;
        $display("FAIL tag_write unexpected: got idx=%h tag=%h, required none", tag_idx, tag_wdata);
      end else begin
        e_tag = exp_tag_q.pop_front();
        if ({tag_idx, tag_wdata} !== e_tag) begin
          errors++;
          $display("FAIL tag_write: got %h required %h", {tag_idx, tag_wdata}, e_tag);
        end
      end
    end
    if (rst_aL && fill_done) fill_cnt++;
  end

  // driver: present a miss, expect acceptance, leave with DUT in REQ
  task automatic drive_miss(input logic [ADDR_WIDTH-1:0] addr);
    @(posedge clk); #1;
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(negedge clk);
    checks++;
    if (miss_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_accept: got ready=%b req_valid=%b required 1 0", miss_ready, mem_req_valid);
    end
    @(posedge clk); #1;
    miss_valid = 1'b0;
  endtask

  // driver: request handshake after 'delay' stalled cycles; junk beats are offered while stalled
  task automatic do_handshake(input int delay, input logic [ADDR_WIDTH-1:0] exp_addr);
    for (int i = 0; i < delay; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr || sram_csb !== 1'b1) begin
        errors++;
        $display("FAIL req_stall: got valid=%b addr=%h csb=%b required 1 %h 1", mem_req_valid, mem_req_addr, sram_csb, exp_addr);
      end
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr) begin
      errors++;
      $display("FAIL req_handshake: got valid=%b addr=%h required 1 %h", mem_req_valid, mem_req_addr, exp_addr);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
  endtask

  // driver: one response beat; its SRAM write is expected next cycle
  task automatic send_beat(input logic [BEAT_WIDTH-1:0] d, input logic [1:0] mask, input logic [INDEX_WIDTH-1:0] idx);
    exp_wr_q.push_back({mask, idx, d, d});
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = {$urandom, $urandom};
  endtask

  // full refill scenario
  task automatic run_fill(input logic [ADDR_WIDTH-1:0] addr, input int delay, input int gap,
                          input bit flush_hs, input logic [BEAT_WIDTH-1:0] d0,
                          input logic [BEAT_WIDTH-1:0] d1, input int exp_fill);
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    int w0, f0, t0;
    idx = addr[9:4];
    tag = addr[31:10];
    w0 = wr_cnt; f0 = fill_cnt; t0 = tag_cnt;
    drive_miss(addr);
    do_handshake(delay, {addr[31:4], 4'h0});
    if (flush_hs) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    send_beat(d0, 2'b01, idx);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      checks++;
      if ((i > 0 && sram_csb !== 1'b1) || tag_we !== 1'b0) begin
        errors++;
        $display("FAIL beat_gap: got csb=%b tag_we=%b required 1 0", sram_csb, tag_we);
      end
      @(posedge clk); #1;
    end
    exp_tag_q.push_back({idx, tag});
    send_beat(d1, 2'b10, idx);
    @(negedge clk);
    checks++;
    if (tag_we !== 1'b1 || fill_done !== (exp_fill != 0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle: got tag_we=%b fill_done=%b busy=%b required 1 %0d 1", tag_we, fill_done, busy, exp_fill);
    end
    @(posedge clk); #1;
    checks++;
    if (miss_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: got ready=%b busy=%b required 1 0", miss_ready, busy);
    end
    checks++;
    if (wr_cnt - w0 != 2 || fill_cnt - f0 != exp_fill || tag_cnt - t0 != 1 ||
        exp_wr_q.size() != 0 || exp_tag_q.size() != 0) begin
      errors++;
      $display("FAIL fill_counts: got writes=%0d fills=%0d tags=%0d required 2 %0d 1", wr_cnt - w0, fill_cnt - f0, tag_cnt - t0, exp_fill);
    end
  endtask

  task automatic test_reset;
    rst_aL = 1'b0;
    fetch_csb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || miss_ready !== 1'b1 || sram_csb !== 1'b1 || sram_web !== 1'b1 ||
        sram_wmask !== 2'b00 || sram_din !== '0 || mem_req_valid !== 1'b0 || mem_req_addr !== '0 ||
        tag_we !== 1'b0 || tag_idx !== '0 || tag_wdata !== '0 || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b rdy=%b csb=%b web=%b wm=%b reqv=%b reqa=%h twe=%b tidx=%h tw=%h fd=%b required 0 1 1 1 00 0 0 0 0 0 0",
               busy, miss_ready, sram_csb, sram_web, sram_wmask, mem_req_valid, mem_req_addr, tag_we, tag_idx, tag_wdata, fill_done);
    end
    @(posedge clk); #1;
    rst_aL = 1'b1;
    fetch_csb = 1'b1;
  endtask

  task automatic test_idle_passthrough;
    @(posedge clk); #1;
    fetch_csb  = 1'b0;
    fetch_addr = 6'h3F;
    @(negedge clk);
    checks++;
    if (sram_csb !== 1'b0 || sram_web !== 1'b1 || sram_addr !== 6'h3F || sram_wmask !== 2'b00 || sram_din !== '0) begin
      errors++;
      $display("FAIL idle_passthrough: got csb=%b web=%b addr=%h wm=%b required 0 1 3f 00", sram_csb, sram_web, sram_addr, sram_wmask);
    end
    @(posedge clk); #1;
    fetch_csb = 1'b1;
  endtask

  task automatic test_basic_fill;
    logic [LINE_WIDTH-1:0] exp_line;
    exp_line = {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
    run_fill(32'h0000_1234, 0, 0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1);
    checks++;
    if (sram_model[6'h23] !== exp_line) begin
      errors++;
      $display("FAIL basic_readback: got %h required %h", sram_model[6'h23], exp_line);
    end
  endtask

  task automatic test_backpressure;
    fetch_csb  = 1'b0;
    fetch_addr = 6'h11;
    run_fill(32'hDEAD_BEE0, 5, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1);
    fetch_csb = 1'b1;
  endtask

  task automatic test_beat_gaps;
    run_fill(32'h0ACE_0F70, 1, 3, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1);
  endtask

  task automatic test_flush_req;
    int t0;
    t0 = tag_cnt;
    // flush together with a miss blocks acceptance
    @(posedge clk); #1;
    miss_valid = 1'b1; miss_addr = 32'h0000_4440; flush = 1'b1;
    @(posedge clk); #1;
    miss_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept: got busy=%b req_valid=%b required 0 0", busy, mem_req_valid);
    end
    // flush while the request is stalled
    drive_miss(32'h0000_8880);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || miss_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: got busy=%b ready=%b req_valid=%b required 0 1 0", busy, miss_ready, mem_req_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tag_cnt != t0 || wr_cnt < 0) begin
      errors++;
      $display("FAIL flush_req_tag: got tag writes=%0d required 0", tag_cnt - t0);
    end
  endtask

  task automatic test_flush_after_hs;
    run_fill(32'h1234_5670, 0, 1, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 64'hBEEF_BEEF_0000_1111, 0);
    // a following normal fill reports fill_done again
    run_fill(32'h1234_5680, 0, 0, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1);
  endtask

  task automatic test_reset_mid_refill;
    int t0;
    t0 = tag_cnt;
    drive_miss(32'h0000_0550);
    do_handshake(0, 32'h0000_0550);
    send_beat(64'h7777_7777_7777_7777, 2'b01, 6'h15);
    @(posedge clk); #1;
    rst_aL = 1'b0;
    fetch_csb = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || miss_ready !== 1'b1 || sram_csb !== 1'b1 || tag_we !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_refill: got busy=%b ready=%b csb=%b tag_we=%b reqv=%b required 0 1 1 0 0", busy, miss_ready, sram_csb, tag_we, mem_req_valid);
    end
    @(posedge clk); #1;
    rst_aL = 1'b1;
    fetch_csb = 1'b1;
    checks++;
    if (tag_cnt != t0 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_refill_writes: got tag writes=%0d pending=%0d required 0 0", tag_cnt - t0, exp_wr_q.size());
    end
    run_fill(32'h0000_0560, 2, 1, 1'b0, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000, 1);
  endtask

  task automatic test_back_to_back;
    run_fill(32'h0000_03F0, 0, 0, 1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1);
    run_fill(32'hFFFF_FFF8, 0, 0, 1'b0, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      run_fill($urandom, $urandom_range(0, 4), $urandom_range(0, 3), 1'b0,
               {$urandom, $urandom}, {$urandom, $urandom}, 1);
    end
  endtask

  initial begin
    miss_valid     = 1'b0;
    miss_addr      = '0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    fetch_csb      = 1'b1;
    fetch_addr     = '0;
    rst_aL         = 1'b0;
    for (int i = 0; i < 64; i++) sram_model[i] = '0;

    test_reset;
    test_idle_passthrough;
    test_basic_fill;
    test_backpressure;
    test_beat_gaps;
    test_flush_req;
    test_flush_after_hs;
    test_reset_mid_refill;
    test_back_to_back;
    test_random;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss handler that sits directly upstream of the 64x128 icache data SRAM (64-bit write granularity).
- On an icache miss it issues a line-aligned memory request and receives the 128-bit line as two 64-bit beats.
- It writes each beat into the data SRAM half-line using the write mask, then updates the tag/valid array.
- It owns the SRAM port while busy; fetch's SRAM requests pass through only when it is idle.

Parameters:
ADDR_WIDTH, 32, byte address width
INDEX_WIDTH, 6, set index bits (64 lines, direct-mapped)
OFFSET_WIDTH, 4, byte offset in a 16-byte line
BEAT_WIDTH, 64, memory response beat width; also the SRAM write-mask granule
LINE_WIDTH, 128, line width (2 beats)
TAG_WIDTH, 22, equal to ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH

Ports:
clk  in  1  core clock
rst_aL  in  1  synchronous active-low reset
miss_valid  in  1  fetch reports a miss
miss_addr  in  ADDR_WIDTH  missing fetch address
miss_ready  out  1  miss accepted (high only in IDLE)
flush  in  1  pipeline redirect
mem_req_valid  out  1  line read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  line-aligned address, low OFFSET_WIDTH bits zero
mem_resp_valid  in  1  beat valid
mem_resp_data  in  BEAT_WIDTH  beat data, low half first
fetch_csb  in  1  fetch SRAM chip select, active low
fetch_addr  in  INDEX_WIDTH  fetch SRAM index
sram_csb  out  1  to SRAM csb0
sram_web  out  1  to SRAM web0
sram_wmask  out  2  to SRAM wmask0
sram_addr  out  INDEX_WIDTH  to SRAM addr0
sram_din  out  LINE_WIDTH  to SRAM din0
tag_we  out  1  tag/valid array write strobe
tag_idx  out  INDEX_WIDTH  tag array index
tag_wdata  out  TAG_WIDTH  tag written; valid bit set implicitly
busy  out  1  refill in progress; fetch must stall
fill_done  out  1  one-cycle pulse when the line is installed

Behaviour:
- FSM states and transitions:
  - IDLE -> REQ on miss_valid && !flush.
  - REQ -> BEAT0 on mem_req_ready; REQ -> IDLE on flush before the handshake.
  - BEAT0 -> BEAT1 on mem_resp_valid.
  - BEAT1 -> DONE on mem_resp_valid.
  - DONE -> IDLE unconditionally.
- Miss capture:
  - In IDLE, miss_ready=1.
  - On accept, register tag and index from miss_addr.
  - A flush in the same cycle as miss_valid blocks the accept.
- Request channel:
  - mem_req_valid=1 throughout REQ.
  - mem_req_addr is held stable until the handshake.
  - mem_req_valid appears the cycle after the miss is accepted.
- Beat handling:
  - A beat accepted in BEAT0 or BEAT1 is written in the following cycle, using registered outputs.
  - Write drive: sram_csb=0, sram_web=0, sram_addr=captured index, sram_din={beat,beat}.
  - sram_wmask=2'b01 for beat0 and 2'b10 for beat1.
  - The beat0 write is driven during BEAT1's first cycle only. The beat1 write is driven in DONE.
- Idle SRAM cycles:
  - In BEAT states, any cycle without a pending write drives sram_csb=1.
  - mem_resp_valid is ignored outside BEAT0/BEAT1.
- DONE state:
  - tag_we=1 with tag_idx/tag_wdata=captured values.
  - fill_done=1 unless a flush was seen after the request handshake; in that case the drop flag suppresses fill_done only, and the line is still installed.
  - The drop flag clears on entry to IDLE.
- Latency: the last beat is accepted at cycle N; the SRAM write and tag write occur at N+1; the next miss can be accepted at N+2.
- SRAM port mux:
  - busy = (state != IDLE).
  - In IDLE: sram_csb=fetch_csb, sram_web=1, sram_addr=fetch_addr, sram_wmask=2'b00, sram_din=0. This path is combinational.
  - While busy, fetch inputs are ignored.
- Reset (rst_aL=0 at posedge):
  - State returns to IDLE from any state, including mid-refill; the drop flag and captured registers are cleared.
  - All registered outputs are inactive: mem_req_valid=0, tag_we=0, fill_done=0, busy=0, miss_ready=1, sram_web=1, sram_wmask=0, sram_din=0, mem_req_addr=0, tag_idx=0, tag_wdata=0.
  - While rst_aL=0, sram_csb=1 regardless of fetch_csb.
  - A partially written line is left in the SRAM, and its tag is not written.
- No error or retry handling: the memory always returns exactly 2 beats per request.

Decomposition:
- Shared package icache_pkg holds:
  - the width constants INDEX_WIDTH, OFFSET_WIDTH, TAG_WIDTH, BEAT_WIDTH, LINE_WIDTH;
  - the FSM state enum refill_state_t;
  - helper functions addr_tag(), addr_index(), line_align().
- One sub-module, icache_sram_port_mux, is natural: the combinational fetch/refill selection onto the SRAM pins.

Test Plan:
- Basic fill:
  - Stimulus: miss_addr=0x0000_1234, request ready immediately, beats 0xAAAA_AAAA_AAAA_AAAA then 0x5555_5555_5555_5555 on consecutive cycles.
  - Response: mem_req_addr=0x0000_1230; SRAM writes at index 0x23 with wmask 01 then 10; tag_wdata=0x4; one fill_done pulse; a read of index 0x23 returns 0x5555..5555_AAAA..AAAA.
- Request backpressure: mem_req_ready held low for 5 cycles -> mem_req_valid and mem_req_addr stay stable; no SRAM write occurs before the handshake.
- Beat gaps: 3 idle cycles between beats -> sram_csb=1 in the gaps; exactly two writes occur; tag_we is asserted only in DONE.
- Flush:
  - Flush in REQ before ready -> return to IDLE; no tag_we.
  - Flush after the handshake -> both beats are written and tag_we=1, but fill_done=0.
- Reset mid-refill: rst_aL=0 in BEAT1 -> next cycle busy=0, miss_ready=1, sram_csb=1, no tag write; a new miss then refills correctly.
- Idle passthrough: in IDLE, fetch_csb=0, fetch_addr=0x3F -> sram_csb=0, sram_web=1, sram_addr=0x3F in the same cycle; while busy, fetch_csb=0 is ignored.
